spi_reg_writer: RTL and testbench

SPI controller that drives the board's SPI register-write protocol from the parallel side. It accepts one (address, data) write request per handshake and serialises it as two nCS-framed bytes on SCLK/COPI: a write-command address byte, then the data byte. It sits in test/bring-up logic and host bridges, driving the on-chip SPI register peripheral that holds the output-enable, PWM-enable and PWM duty-cycle registers.

---
 rtl/spi_reg_writer_pkg.sv | 32 +++
 rtl/spi_reg_writer_byte_tx.sv | 134 +++++++++++++
 rtl/spi_reg_writer.sv | 105 ++++++++++
 tb/tb_spi_reg_writer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_writer_pkg.sv
// Shared definitions for the SPI register-write protocol: register map,
// command-byte format and the controller state encoding.
package spi_reg_writer_pkg;

  localparam logic [3:0] REG_EN_OUT_7_0  = 4'd0;
  localparam logic [3:0] REG_EN_OUT_15_8 = 4'd1;
  localparam logic [3:0] REG_EN_PWM_7_0  = 4'd2;
  localparam logic [3:0] REG_EN_PWM_15_8 = 4'd3;
  localparam logic [3:0] REG_PWM_DUTY    = 4'd4;
  localparam int         NUM_REGS        = 5;

  // Bit 7 of the address byte marks a write command.
  localparam logic WRITE_CMD = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    TAIL,
    GAP,
    DONE
  } state_t;

  function automatic logic [7:0] cmd_byte(input logic [3:0] addr);
    return {WRITE_CMD, 3'b000, addr};
  endfunction

  function automatic logic addr_valid(input logic [3:0] addr);
    return int'(addr) < NUM_REGS;
  endfunction

endpackage

// File: rtl/spi_reg_writer_byte_tx.sv
// Transmits one nCS-framed byte, SPI mode 0, MSB first, followed by the
// mandatory nCS-high gap. fin is asserted during the last gap cycle; if start
// is high in that cycle the next frame begins on the following edge with no
// extra idle cycle, which keeps the two bytes of a write exactly CS_GAP apart.
//
//   state | meaning
//   IDLE  | nCS high, waiting for start
//   LOAD  | nCS low, bit 7 on COPI, first half-period before SCLK rises
//   SHIFT | SCLK toggling; COPI advances on each falling toggle
//   TAIL  | SCLK low for one half-period before nCS rises
//   GAP   | nCS high for CS_GAP cycles
module spi_byte_tx
  import spi_reg_writer_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx_byte,
  output logic       fin,
  output logic       sclk,
  output logic       ncs,
  output logic       copi
);

  localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(CS_GAP - 1);

  state_t           st, st_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_cnt;
  logic [2:0]       bit_nxt;
  logic [7:0]       byte_q;
  logic             cnt_zero;
  logic             load_byte;

  assign cnt_zero = (cnt == '0);
  assign bit_nxt  = bit_cnt - 3'd1;
  assign fin      = (st == GAP) && cnt_zero;

  // Next-state decode; load_byte marks the edge on which a frame opens.
  always_comb begin
    st_nxt    = st;
    load_byte = 1'b0;
    case (st)
      IDLE: begin
        if (start) begin
          st_nxt    = LOAD;
          load_byte = 1'b1;
        end
      end
      LOAD:  if (cnt_zero) st_nxt = SHIFT;
      SHIFT: if (cnt_zero && sclk && (bit_cnt == 3'd0)) st_nxt = TAIL;
      TAIL:  if (cnt_zero) st_nxt = GAP;
      GAP: begin
        if (cnt_zero) begin
          if (start) begin
            st_nxt    = LOAD;
            load_byte = 1'b1;
          end else begin
            st_nxt = IDLE;
          end
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nxt;
  end

  // Half-period timer, bit pointer and the registered SPI pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      bit_cnt <= 3'd0;
      byte_q  <= 8'h00;
      sclk    <= 1'b0;
      ncs     <= 1'b1;
      copi    <= 1'b0;
    end else if (load_byte) begin
      byte_q  <= tx_byte;
      bit_cnt <= 3'd7;
      copi    <= tx_byte[7];
      ncs     <= 1'b0;
      sclk    <= 1'b0;
      cnt     <= DIV_LD;
    end else begin
      case (st)
        LOAD: begin
          if (cnt_zero) begin
            sclk <= 1'b1;
            cnt  <= DIV_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SHIFT: begin
          if (cnt_zero) begin
            cnt  <= DIV_LD;
            sclk <= ~sclk;
            if (sclk) begin
              bit_cnt <= bit_nxt;
              if (bit_cnt != 3'd0) copi <= byte_q[bit_nxt];
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        TAIL: begin
          if (cnt_zero) begin
            ncs  <= 1'b1;
            copi <= 1'b0;
            cnt  <= GAP_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (!cnt_zero) cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/spi_reg_writer.sv
// Parallel-to-SPI register writer. Each accepted request becomes an address
// byte {1,000,addr} followed by the data byte, each in its own nCS frame.
// Out-of-range addresses are answered with done+err and no SPI traffic.
//
//   state | meaning
//   IDLE  | waiting for a request, req_ready high
//   LOAD  | request captured; byte frames in flight (or address being rejected)
//   DONE  | done pulse cycle; a new request may be accepted here
module spi_reg_writer
  import spi_reg_writer_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_addr,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       SCLK,
  output logic       nCS,
  output logic       COPI
);

  state_t     state, state_nxt;
  logic [3:0] addr_q;
  logic [7:0] data_q;
  logic       byte_sel;
  logic       start_q;
  logic       accept;
  logic       addr_ok;
  logic       tx_start;
  logic       tx_fin;
  logic [7:0] tx_byte;

  assign accept  = req_valid && req_ready;
  assign addr_ok = addr_valid(addr_q);

  // The data byte is chained straight off the end of the address frame's gap.
  assign tx_start = start_q || (tx_fin && !byte_sel);
  assign tx_byte  = start_q ? cmd_byte(addr_q) : data_q;

  spi_byte_tx #(
    .CLK_DIV (CLK_DIV),
    .CS_GAP  (CS_GAP)
  ) u_byte_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (tx_start),
    .tx_byte (tx_byte),
    .fin     (tx_fin),
    .sclk    (SCLK),
    .ncs     (nCS),
    .copi    (COPI)
  );

  // Request sequencing.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = LOAD;
      LOAD: if (!addr_ok || (tx_fin && byte_sel)) state_nxt = DONE;
      DONE: state_nxt = accept ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Request capture, byte sequencing and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= 4'h0;
      data_q    <= 8'h00;
      byte_sel  <= 1'b0;
      start_q   <= 1'b0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      start_q <= accept && addr_valid(req_addr);
      if (accept) begin
        addr_q   <= req_addr;
        data_q   <= req_data;
        byte_sel <= 1'b0;
      end else if ((state == LOAD) && tx_fin && !byte_sel) begin
        byte_sel <= 1'b1;
      end
      req_ready <= (state_nxt == IDLE) || (state_nxt == DONE);
      busy      <= (state_nxt == LOAD);
      done      <= (state_nxt == DONE);
      err       <= (state_nxt == DONE) && !addr_ok;
    end
  end

endmodule

// File: tb/tb_spi_reg_writer.sv
// Bench for spi_reg_writer: a behavioural SPI register peripheral decodes the
// serial traffic, and a plain register-array model plus frame timing
// arithmetic provide the expected results.
module tb_spi_reg_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       req_valid_d, req_ready_d, busy_d, done_d, err_d, sclk_d, ncs_d, copi_d;
  logic [3:0] req_addr_d;
  logic [7:0] req_data_d;
  logic       req_valid_f, req_ready_f, busy_f, done_f, err_f, sclk_f, ncs_f, copi_f;
  logic [3:0] req_addr_f;
  logic [7:0] req_data_f;

  spi_reg_writer dut_d (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_d), .req_ready(req_ready_d),
    .req_addr(req_addr_d), .req_data(req_data_d), .busy(busy_d), .done(done_d),
    .err(err_d), .SCLK(sclk_d), .nCS(ncs_d), .COPI(copi_d)
  );

  spi_reg_writer #(.CLK_DIV(2), .CS_GAP(4)) dut_f (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_f), .req_ready(req_ready_f),
    .req_addr(req_addr_f), .req_data(req_data_f), .busy(busy_f), .done(done_f),
    .err(err_f), .SCLK(sclk_f), .nCS(ncs_f), .COPI(copi_f)
  );

  // sel chooses which instance the peripheral and the checks observe.
  logic sel = 1'b0;
  logic m_sclk, m_ncs, m_copi, m_ready, m_done, m_err;
  assign m_sclk  = sel ? sclk_f      : sclk_d;
  assign m_ncs   = sel ? ncs_f       : ncs_d;
  assign m_copi  = sel ? copi_f      : copi_d;
  assign m_ready = sel ? req_ready_f : req_ready_d;
  assign m_done  = sel ? done_f      : done_d;
  assign m_err   = sel ? err_f       : err_d;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Peripheral: 8 bits per frame or the frame is discarded; an address byte
  // with bit 7 set followed by a data byte performs the write.
  logic [7:0] pregs [5] = '{default: 8'h00};
  logic [7:0] p_sh = 8'h00;
  int         p_nbits = 0;
  logic       p_have_cmd = 1'b0;
  logic [3:0] p_addr = 4'h0;
  logic [7:0] bq [$];

  always @(posedge m_sclk or posedge m_ncs) begin
    if (m_ncs) begin
      if (p_nbits == 8) begin
        bq.push_back(p_sh);
        if (p_have_cmd) begin
          if (int'(p_addr) < 5) pregs[int'(p_addr)] = p_sh;
          p_have_cmd = 1'b0;
        end else if (p_sh[7]) begin
          p_have_cmd = 1'b1;
          p_addr     = p_sh[3:0];
        end
      end else if (p_nbits != 0) begin
        p_have_cmd = 1'b0;
      end
      p_nbits = 0;
    end else begin
      p_sh    = {p_sh[6:0], m_copi};
      p_nbits = p_nbits + 1;
    end
  end

  logic [7:0] exp_regs [5] = '{default: 8'h00};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [7:0] d);
    if (sel) begin
      req_valid_f = v; req_addr_f = a; req_data_f = d;
    end else begin
      req_valid_d = v; req_addr_d = a; req_data_d = d;
    end
  endtask

  // Presents a request and returns the accept edge index.
  task automatic issue(input logic [3:0] a, input logic [7:0] d, output int e0);
    int k = 0;
    @(negedge clk);
    drive(1'b1, a, d);
    while (!m_ready && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("accept_ready", 32'(m_ready), 32'd1);
    @(negedge clk);
    e0 = cyc;
    drive(1'b0, a, d);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 5; i++)
      chk($sformatf("%s_reg%0d", tag, i), 32'(pregs[i]), 32'(exp_regs[i]));
  endtask

  // One complete request with frame timing, byte content and register checks.
  task automatic check_req(input logic [3:0] a, input logic [7:0] d);
    int   e0, base, dv, gv;
    int   f0 = -1, r0 = -1, f1 = -1, r1 = -1, t_done = -1, b0, b1;
    logic err_o = 1'b0, rdy_o = 1'b0, pn, done_after;
    logic valid;
    valid = (int'(a) <= 4);
    dv    = sel ? 2 : 4;
    gv    = sel ? 4 : 8;
    base  = bq.size();
    issue(a, d, e0);
    pn = m_ncs;
    for (int k = 0; k < 3000 && t_done < 0; k++) begin
      @(negedge clk);
      if (pn && !m_ncs) begin
        if (f0 < 0) f0 = cyc; else f1 = cyc;
      end
      if (!pn && m_ncs) begin
        if (r0 < 0) r0 = cyc; else r1 = cyc;
      end
      pn = m_ncs;
      if (m_done) begin
        t_done = cyc;
        err_o  = m_err;
        rdy_o  = m_ready;
      end
    end
    @(negedge clk);
    done_after = m_done;
    chk("done_width", 32'(done_after), 32'd0);
    chk("ready_at_done", 32'(rdy_o), 32'd1);
    chk("err", 32'(err_o), 32'(!valid));
    if (valid) begin
      chk("done_time", t_done, e0 + 1 + 34 * dv + 2 * gv);
      chk("ncs_fall0", f0, e0 + 1);
      chk("ncs_low0", r0 - f0, 17 * dv);
      chk("ncs_gap", f1 - r0, gv);
      chk("ncs_low1", r1 - f1, 17 * dv);
      b0 = (bq.size() > base)     ? int'(bq[base])     : -1;
      b1 = (bq.size() > base + 1) ? int'(bq[base + 1]) : -1;
      chk("byte_addr", b0, 32'h80 + int'(a));
      chk("byte_data", b1, int'(d));
      exp_regs[int'(a)] = d;
      chk("reg_write", 32'(pregs[int'(a)]), 32'(exp_regs[int'(a)]));
    end else begin
      chk("rej_done_time", t_done, e0 + 1);
      chk("rej_ncs_silent", f0, -1);
      chk("rej_no_bytes", bq.size() - base, 0);
    end
  endtask

  initial begin
    int   e0a, e0b, t1, t2, nf, nr, k;
    logic rdy, hit, seen_done, ps, pn, bad;

    rst_n = 1'b0;
    req_valid_d = 1'b0; req_addr_d = 4'h0; req_data_d = 8'h00;
    req_valid_f = 1'b0; req_addr_f = 4'h0; req_data_f = 8'h00;
    repeat (5) @(negedge clk);
    chk("reset_outs_d", 32'({req_ready_d, busy_d, done_d, err_d, sclk_d, ncs_d, copi_d}), 32'h42);
    chk("reset_outs_f", 32'({req_ready_f, busy_f, done_f, err_f, sclk_f, ncs_f, copi_f}), 32'h42);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (sclk_d || !ncs_d || sclk_f || !ncs_f || busy_d || done_d) bad = 1'b1;
    end
    chk("idle_200", 32'(bad), 32'd0);

    // Directed write to the PWM duty register.
    check_req(4'd4, 8'h80);

    // Rejected address.
    check_req(4'd7, 8'h55);

    // Back-to-back: valid held, second request taken in the first done cycle.
    t1 = -1; t2 = -1; rdy = 1'b0;
    @(negedge clk);
    drive(1'b1, 4'd0, 8'hFF);
    @(negedge clk);
    e0a = cyc;
    drive(1'b1, 4'd1, 8'h0F);
    for (int i = 0; i < 3000 && t1 < 0; i++) begin
      @(negedge clk);
      if (done_d) begin
        t1  = cyc;
        rdy = req_ready_d;
      end
    end
    chk("b2b_done1", t1, e0a + 153);
    chk("b2b_ready_in_done", 32'(rdy), 32'd1);
    @(negedge clk);
    e0b = cyc;
    chk("b2b_taken", 32'({req_ready_d, busy_d}), 32'b01);
    drive(1'b0, 4'd1, 8'h0F);
    for (int i = 0; i < 3000 && t2 < 0; i++) begin
      @(negedge clk);
      if (done_d) t2 = cyc;
    end
    chk("b2b_done2", t2, e0b + 153);
    exp_regs[0] = 8'hFF;
    exp_regs[1] = 8'h0F;
    check_regs("b2b");

    // Randomised writes, including out-of-range addresses.
    repeat (6) check_req(4'($urandom_range(0, 7)), 8'($urandom));
    check_regs("rand");

    // Reset during the 5th SCLK high of the data byte.
    issue(4'd2, ~exp_regs[2], e0a);
    nf = 0; nr = 0; hit = 1'b0; seen_done = 1'b0;
    ps = sclk_d; pn = ncs_d;
    k = 0;
    while (!hit && k < 2000) begin
      @(negedge clk);
      if (pn && !ncs_d) nf++;
      if (!ps && sclk_d && nf == 2) nr++;
      ps = sclk_d;
      pn = ncs_d;
      if (done_d) seen_done = 1'b1;
      if (nr == 5) hit = 1'b1;
      k++;
    end
    chk("abort_reached", 32'(hit), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_outs", 32'({req_ready_d, busy_d, done_d, err_d, sclk_d, ncs_d, copi_d}), 32'h42);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done_d) seen_done = 1'b1;
    end
    chk("abort_no_done", 32'(seen_done), 32'd0);
    check_regs("abort");

    // Minimum legal divider and gap.
    sel = 1'b1;
    for (int i = 0; i < 5; i++) check_req(4'(i), 8'hA0 + 8'(i));
    check_regs("fast");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
